// File: rtl/rv32_decode_pkg.sv
// Shared encodings for the RV32 decode stage: opcodes, write-back source select and
// the registered ID/EX payload layout.
package rv32_decode_pkg;

    localparam logic [6:0] OPC_L     = 7'b0000011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_RM    = 7'b0110011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_CSR   = 7'b1110011;
    localparam logic [6:0] OPC_FENCE = 7'b0001111;

    localparam logic [6:0] FUNCT7_M  = 7'b0000001;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_CSR = 2'd2,
        WB_PC4 = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        alu1_pc;
        logic        alu2_imm;
        logic        mem_rd;
        logic        mem_wr;
        wb_src_e     wb_src;
        logic        rwe;
        logic [4:0]  rd;
        logic        illegal;
    } idex_t;

endpackage

// File: rtl/rv32_decode_stage_imm_gen.sv
// Immediate former: picks the I/S/B/U/J/CSR immediate layout from the opcode.
module rv32_imm_gen
    import rv32_decode_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [31:0] immediate
);

    logic [6:0] opcode;

    always_comb begin
        opcode    = instruction[6:0];
        immediate = 32'd0;
        case (opcode)
            OPC_L, OPC_I, OPC_JALR:
                immediate = {{20{instruction[31]}}, instruction[31:20]};
            OPC_S:
                immediate = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            OPC_B:
                immediate = {{19{instruction[31]}}, instruction[31], instruction[7],
                             instruction[30:25], instruction[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                immediate = {instruction[31:12], 12'd0};
            OPC_JAL:
                immediate = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                             instruction[20], instruction[30:21], 1'b0};
            // CSR carries the CSR address, so it is zero-extended
            OPC_CSR:
                immediate = {20'd0, instruction[31:20]};
            default:
                immediate = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32 decode stage: decodes the offered instruction into a registered ID/EX slot,
// with load-use bubble insertion, flush and a saturating stall counter.
module rv32_decode_stage
    import rv32_decode_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter bit ENABLE_M   = 1'b1,
    parameter bit ENABLE_CSR = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_valid,
    output logic                 if_ready,
    input  logic [31:0]          if_instruction,
    input  logic [PC_WIDTH-1:0]  if_pc,
    input  logic                 flush,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [PC_WIDTH-1:0]  ex_pc,
    output logic [2:0]           ex_funct3,
    output logic [6:0]           ex_funct7,
    output logic [4:0]           regs_reg1_read_address,
    output logic [4:0]           regs_reg2_read_address,
    output logic [31:0]          ex_immediate,
    output logic                 ex_aluop1_source,
    output logic                 ex_aluop2_source,
    output logic                 memory_read_enable,
    output logic                 memory_write_enable,
    output logic [1:0]           wb_reg_write_source,
    output logic                 reg_write_enable,
    output logic [4:0]           reg_write_address,
    output logic                 illegal_instruction,
    output logic [CNT_WIDTH-1:0] stall_count
);

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        uses_rs1, uses_rs2, writes_rd, illegal;
    logic        alu1_pc, alu2_imm, is_load, is_store;
    wb_src_e     wb_src;
    idex_t       dec;

    logic                 ex_valid_q, ex_valid_d;
    idex_t                idex_q, idex_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic                 hazard, accept, advance;

    rv32_imm_gen u_imm_gen (
        .instruction (if_instruction),
        .immediate   (imm)
    );

    always_comb begin
        opcode    = if_instruction[6:0];
        rd        = if_instruction[11:7];
        rs1       = if_instruction[19:15];
        rs2       = if_instruction[24:20];
        funct7    = if_instruction[31:25];
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        writes_rd = 1'b1;
        illegal   = 1'b0;
        alu1_pc   = 1'b0;
        alu2_imm  = 1'b1;
        is_load   = 1'b0;
        is_store  = 1'b0;
        wb_src    = WB_ALU;
        case (opcode)
            OPC_L: begin
                is_load = 1'b1;
                wb_src  = WB_MEM;
            end
            OPC_I: begin
            end
            OPC_S: begin
                is_store  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b0;
            end
            OPC_RM: begin
                uses_rs2 = 1'b1;
                alu2_imm = 1'b0;
                if (funct7 == FUNCT7_M && !ENABLE_M) illegal = 1'b1;
            end
            OPC_B: begin
                uses_rs2  = 1'b1;
                alu1_pc   = 1'b1;
                alu2_imm  = 1'b0;
                writes_rd = 1'b0;
            end
            OPC_LUI: begin
                uses_rs1 = 1'b0;
            end
            OPC_AUIPC: begin
                uses_rs1 = 1'b0;
                alu1_pc  = 1'b1;
            end
            OPC_JAL: begin
                uses_rs1 = 1'b0;
                alu1_pc  = 1'b1;
                wb_src   = WB_PC4;
            end
            OPC_JALR: begin
                wb_src = WB_PC4;
            end
            OPC_CSR: begin
                wb_src = WB_CSR;
                if (!ENABLE_CSR) illegal = 1'b1;
            end
            OPC_FENCE: begin
                writes_rd = 1'b0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        dec.funct3   = if_instruction[14:12];
        dec.funct7   = funct7;
        dec.rs1      = uses_rs1 ? rs1 : 5'd0;
        dec.rs2      = uses_rs2 ? rs2 : 5'd0;
        dec.imm      = imm;
        dec.alu1_pc  = alu1_pc;
        dec.alu2_imm = alu2_imm;
        dec.mem_rd   = is_load & ~illegal;
        dec.mem_wr   = is_store & ~illegal;
        dec.wb_src   = wb_src;
        dec.rwe      = writes_rd & ~illegal & (rd != 5'd0);
        dec.rd       = rd;
        dec.illegal  = illegal;
    end

    // Load in the ID/EX slot whose rd feeds the offered instruction cannot forward in time.
    assign hazard = ex_valid_q & idex_q.mem_rd & (idex_q.rd != 5'd0) & if_valid &
                    ((uses_rs1 & (rs1 == idex_q.rd)) | (uses_rs2 & (rs2 == idex_q.rd)));

    assign advance  = ~ex_valid_q | ex_ready;
    assign if_ready = advance & ~hazard;
    assign accept   = if_valid & if_ready & ~flush;

    always_comb begin
        ex_valid_d = ex_valid_q;
        idex_d     = idex_q;
        pc_d       = pc_q;
        stall_d    = stall_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            idex_d     = dec;
            pc_d       = if_pc;
        end else if (advance) begin
            ex_valid_d = 1'b0;
            if (hazard && stall_q != {CNT_WIDTH{1'b1}}) begin
                stall_d = stall_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            idex_q     <= '0;
            pc_q       <= '0;
            stall_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            idex_q     <= idex_d;
            pc_q       <= pc_d;
            stall_q    <= stall_d;
        end
    end

    assign ex_valid               = ex_valid_q;
    assign ex_pc                  = pc_q;
    assign ex_funct3              = idex_q.funct3;
    assign ex_funct7              = idex_q.funct7;
    assign regs_reg1_read_address = idex_q.rs1;
    assign regs_reg2_read_address = idex_q.rs2;
    assign ex_immediate           = idex_q.imm;
    assign ex_aluop1_source       = idex_q.alu1_pc;
    assign ex_aluop2_source       = idex_q.alu2_imm;
    assign memory_read_enable     = idex_q.mem_rd;
    assign memory_write_enable    = idex_q.mem_wr;
    assign wb_reg_write_source    = idex_q.wb_src;
    assign reg_write_enable       = idex_q.rwe;
    assign reg_write_address      = idex_q.rd;
    assign illegal_instruction    = idex_q.illegal;
    assign stall_count            = stall_q;

endmodule

// File: doc/rv32_decode_stage.md
Name: rv32_decode_stage

Overview:
Parametrised RV32 instruction-decode stage with a registered ID/EX output and valid/ready handshakes on both sides. It accepts fetched instructions, produces decoded control, immediate and register-address fields one cycle later, and detects load-use hazards by inserting a bubble. It also supports pipeline flush, optional M/Zicsr legality checking, and a stall counter. It sits between the fetch stage and the execute stage.

Parameters:
PC_WIDTH, 32, width of the instruction address carried with each instruction
ENABLE_M, 1, 1 = funct7 0000001 on the R-type opcode is legal (M extension)
ENABLE_CSR, 1, 1 = opcode 1110011 is legal
CNT_WIDTH, 16, width of stall_count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  fetch offers an instruction
if_ready  out  1  decode accepts this cycle
if_instruction  in  32  instruction word
if_pc  in  PC_WIDTH  instruction address
flush  in  1  kill the held and the offered instruction
ex_valid  out  1  output register holds a valid instruction
ex_ready  in  1  execute consumes this cycle
ex_pc  out  PC_WIDTH  registered PC
ex_funct3  out  3  registered funct3
ex_funct7  out  7  registered funct7
regs_reg1_read_address  out  5  rs1, or 0 when unused
regs_reg2_read_address  out  5  rs2, or 0 when unused
ex_immediate  out  32  sign/zero-formed immediate
ex_aluop1_source  out  1  0 = rs1, 1 = PC
ex_aluop2_source  out  1  0 = rs2, 1 = immediate
memory_read_enable  out  1  load
memory_write_enable  out  1  store
wb_reg_write_source  out  2  0 = ALU, 1 = memory, 2 = CSR, 3 = PC+4
reg_write_enable  out  1  writes rd; forced 0 when rd = 0
reg_write_address  out  5  rd
illegal_instruction  out  1  decode failed
stall_count  out  CNT_WIDTH  load-use bubbles inserted; saturates

Behaviour:
- Reset (rst_n low, asynchronous):
  - every output register clears to 0, including ex_valid, illegal_instruction and stall_count.
  - if_ready is combinational and reads 1 during reset.
- Accept rule: accept = if_valid & if_ready & ~flush.
- if_ready = (~ex_valid | ex_ready) & ~hazard.
- Latency: an accepted instruction appears on the ex_* outputs on the next edge with ex_valid = 1.
- Hold rule: when ex_valid & ~ex_ready, all outputs hold stable.
- Hazard: hazard = ex_valid & memory_read_enable & (reg_write_address != 0) & if_valid & ((uses_rs1 & rs1 == reg_write_address) | (uses_rs2 & rs2 == reg_write_address)).
  - On hazard with ex_ready = 1, the register loads a bubble (ex_valid = 0).
  - stall_count increments by 1, saturating at all-ones.
  - The offered instruction is accepted on the following cycle.
- Flush:
  - Highest priority; ex_valid = 0 on the next edge.
  - The offered instruction is discarded, with no accept and no stall count.
  - Flush and hazard in the same cycle: flush wins, no count.
- Register usage:
  - uses_rs1 is 0 for lui, auipc and jal; in that case regs_reg1_read_address = 0.
  - uses_rs2 is 1 only for the R-type (0110011), store (0100011) and branch (1100011) opcodes; otherwise regs_reg2_read_address = 0.
- Immediates:
  - I / load / jalr: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U: {inst[31:12], 12'b0}.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - CSR: zero-extended inst[31:20].
  - Anything else: 0.
- ex_aluop1_source = 1 for branch, auipc and jal.
- ex_aluop2_source = 0 only for the R-type and branch opcodes.
- wb_reg_write_source: 1 for load, 3 for jal/jalr, 2 for CSR, 0 otherwise.
- reg_write_enable is 0 for store, branch, fence and illegal instructions.
- Illegal instructions:
  - Causes: unknown opcode, M-encoding with ENABLE_M = 0, CSR opcode with ENABLE_CSR = 0.
  - The instruction still passes downstream with illegal_instruction = 1.
  - reg_write_enable, memory_read_enable and memory_write_enable are all 0.
- fence decodes as a legal no-operation.

Decomposition:
- rv32_decode_pkg holds:
  - opcode constants L, I, S, RM, B, LUI, AUIPC, JAL, JALR, CSR, FENCE;
  - the wb-source enum;
  - the M funct7 constant.
- One combinational sub-module, rv32_imm_gen (instruction in, 32-bit immediate out), is instantiated once.

Test Plan:
- addi x1,x2,-5 (0xFFB10093), ex_ready = 1 -> next cycle:
  - ex_valid = 1, ex_immediate = 0xFFFFFFFB;
  - regs_reg1_read_address = 2, regs_reg2_read_address = 0;
  - ex_aluop2_source = 1, reg_write_enable = 1, reg_write_address = 1, wb_reg_write_source = 0.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x7 (0x00728333) back to back:
  - if_ready = 0 for exactly one cycle, one cycle with ex_valid = 0;
  - stall_count = 1, then the add is emitted with regs_reg2_read_address = 7.
- lui x3,0x12345 (0x123451B7) -> ex_immediate = 0x12345000, regs_reg1_read_address = 0, ex_aluop1_source = 0, wb_reg_write_source = 0.
- Backpressure: ex_ready = 0 for 3 cycles with if_valid = 1 -> if_ready = 0, all ex_* outputs stable, no instruction lost or duplicated once ex_ready returns.
- Flush asserted while ex_valid = 1 and if_valid = 1 -> ex_valid = 0 next cycle, offered instruction never appears, stall_count unchanged.
- ENABLE_M = 0, mul x1,x2,x3 (0x023100B3) -> illegal_instruction = 1, reg_write_enable = 0.
  - Same instruction with ENABLE_M = 1 -> illegal_instruction = 0, reg_write_enable = 1.
- Reset mid-operation: rst_n pulled low asynchronously -> ex_valid and stall_count read 0 without waiting for a clock edge.
